trap_controller: RTL and testbench
==================================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath and CSR width.
REQ-002 SHALL have parameter N_EXC, default 16, number of synchronous exception sources (index = cause code).
REQ-003 SHALL have parameter N_IRQ, default 12, number of interrupt sources (index = cause code).
REQ-004 SHALL have port CLK  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port EXC_VALID  in  N_EXC  one bit per exception cause, level, sampled each cycle.
REQ-007 SHALL have port EXC_PC  in  XLEN  PC of faulting instruction.
REQ-008 SHALL have port EXC_TVAL  in  XLEN  fault value (bad address/instruction).
REQ-009 SHALL have port IRQ_PENDING  in  N_IRQ  pending interrupt lines.
REQ-010 SHALL have port IRQ_ENABLE  in  N_IRQ  per-line enable (mie).
REQ-011 SHALL have port GIE  in  1  global interrupt enable (mstatus.MIE).
REQ-012 SHALL have port NEXT_PC  in  XLEN  PC to resume at when an interrupt is taken.
REQ-013 SHALL have port MTVEC  in  XLEN  trap vector; bits[1:0]=01 selects vectored mode.
REQ-014 SHALL have port MRET  in  1  single-cycle pulse, return from handler.
REQ-015 SHALL have port ACK  in  1  pipeline accepted the current redirect.
REQ-016 SHALL have port REDIRECT  out  1  redirect request, held until ACK.
REQ-017 SHALL have port REDIRECT_PC  out  XLEN  redirect target.
REQ-018 SHALL have port CAUSE  out  XLEN  mcause value, MSB = interrupt flag.
REQ-019 SHALL have port EPC  out  XLEN  captured mepc.
REQ-020 SHALL have port TVAL  out  XLEN  captured mtval (0 for interrupts).
REQ-021 SHALL have port IN_TRAP  out  1  high while in handler.
REQ-022 SHALL have port FLUSH  out  1  one-cycle pulse on the cycle a trap is accepted.

Function
REQ-023 SHALL implement states IDLE, ENTER, HANDLER, RETURN.
REQ-024 Trap event SHALL be any EXC_VALID bit, or (GIE && !IN_TRAP && |(IRQ_PENDING & IRQ_ENABLE)).
REQ-025 Exceptions SHALL beat interrupts; lowest set EXC_VALID index wins; highest set enabled IRQ index wins.
REQ-026 In IDLE or HANDLER, trap event at cycle N SHALL register CAUSE/EPC/TVAL and enter ENTER with REDIRECT=1 at N+1.
REQ-027 Exception: CAUSE={0,index}, EPC=EXC_PC, TVAL=EXC_TVAL; interrupt: CAUSE={1,index}, EPC=NEXT_PC, TVAL=0.
REQ-028 REDIRECT_PC SHALL be {MTVEC[XLEN-1:2],2'b00}, plus 4*index when vectored and interrupt; sum wraps modulo 2^XLEN.
REQ-029 ENTER SHALL hold REDIRECT/REDIRECT_PC/CAUSE stable until ACK; ACK cycle: FLUSH=1, next state HANDLER.
REQ-030 HANDLER SHALL assert IN_TRAP; interrupts masked; an exception re-enters ENTER, overwriting CAUSE/EPC/TVAL (nested fault).
REQ-031 MRET in HANDLER with no exception SHALL enter RETURN with REDIRECT=1, REDIRECT_PC=EPC; exception same cycle wins over MRET.
REQ-032 RETURN SHALL hold until ACK; ACK cycle: FLUSH=1, IN_TRAP=0 next cycle, state IDLE.
REQ-033 MRET in IDLE, ENTER or RETURN SHALL be ignored.
REQ-034 EXC_VALID/IRQ SHALL be ignored in ENTER and RETURN (pipeline holds sources until flush).
REQ-035 IRQ pending when IDLE is re-entered SHALL be taken the following cycle (no lost interrupt).

Reset
REQ-036 RST SHALL override all activity, including mid-ENTER/RETURN, next state IDLE.
REQ-037 Reset values: REDIRECT=0, REDIRECT_PC=0, CAUSE=0, EPC=0, TVAL=0, IN_TRAP=0, FLUSH=0.

Verification
REQ-038 EXC_VALID=0x0024, EXC_PC=0x1000, TVAL=0xDEAD, MTVEC=0x8000 -> next cycle REDIRECT=1, CAUSE=2, EPC=0x1000, TVAL=0xDEAD, REDIRECT_PC=0x8000.
REQ-039 GIE=1, IRQ_PENDING=IRQ_ENABLE=0x880, MTVEC=0x8001, NEXT_PC=0x2000 -> CAUSE=0x8000_0000_0000_000B, REDIRECT_PC=0x802C, EPC=0x2000, TVAL=0.
REQ-040 ACK withheld 5 cycles then 1 -> REDIRECT stable 5+1 cycles, FLUSH pulse on ACK cycle, IN_TRAP=1 after; IRQ in HANDLER ignored.
REQ-041 MRET in HANDLER, EPC=0x1000, ACK after 2 cycles -> REDIRECT_PC=0x1000, FLUSH on ACK, IN_TRAP=0 next cycle.
REQ-042 EXC_VALID bit 5 with MRET same cycle in HANDLER -> ENTER, CAUSE=5, no return.
REQ-043 RST asserted while REDIRECT=1 pending ACK -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: prioritises exceptions and interrupts,
// captures mcause/mepc/mtval and drives redirect/flush handshakes.
module trap_controller #(
    parameter int XLEN  = 64,
    parameter int N_EXC = 16,
    parameter int N_IRQ = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_EXC-1:0] EXC_VALID,
    input  logic [XLEN-1:0]  EXC_PC,
    input  logic [XLEN-1:0]  EXC_TVAL,
    input  logic [N_IRQ-1:0] IRQ_PENDING,
    input  logic [N_IRQ-1:0] IRQ_ENABLE,
    input  logic             GIE,
    input  logic [XLEN-1:0]  NEXT_PC,
    input  logic [XLEN-1:0]  MTVEC,
    input  logic             MRET,
    input  logic             ACK,
    output logic             REDIRECT,
    output logic [XLEN-1:0]  REDIRECT_PC,
    output logic [XLEN-1:0]  CAUSE,
    output logic [XLEN-1:0]  EPC,
    output logic [XLEN-1:0]  TVAL,
    output logic             IN_TRAP,
    output logic             FLUSH
);

    localparam int EW = (N_EXC > 1) ? $clog2(N_EXC) : 1;
    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        HANDLER,
        RETURN
    } state_t;

    state_t state, state_nxt;

    logic [N_IRQ-1:0] irq_act;
    logic [EW-1:0]    exc_idx;
    logic [IW-1:0]    irq_idx;
    logic             exc_any;
    logic             irq_any;
    logic             take;
    logic             ret;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  trap_pc;

    assign irq_act = IRQ_PENDING & IRQ_ENABLE;
    assign exc_any = |EXC_VALID;
    assign irq_any = GIE & ~IN_TRAP & (|irq_act);
    assign base    = {MTVEC[XLEN-1:2], 2'b00};

    // Lowest exception index wins, highest interrupt index wins.
    always_comb begin
        exc_idx = '0;
        for (int i = N_EXC - 1; i >= 0; i--) begin
            if (EXC_VALID[i]) exc_idx = EW'(i);
        end
    end

    always_comb begin
        irq_idx = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (irq_act[i]) irq_idx = IW'(i);
        end
    end

    always_comb begin
        trap_pc = base;
        if (!exc_any && MTVEC[1:0] == 2'b01)
            trap_pc = base + (XLEN'(irq_idx) << 2);
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        ret       = 1'b0;
        unique case (state)
            IDLE:    take = exc_any | irq_any;
            ENTER:   if (ACK) state_nxt = HANDLER;
            HANDLER: begin
                take = exc_any;
                ret  = ~exc_any & MRET;
            end
            RETURN:  if (ACK) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (take) state_nxt = ENTER;
        if (ret)  state_nxt = RETURN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            REDIRECT_PC <= '0;
            CAUSE       <= '0;
            EPC         <= '0;
            TVAL        <= '0;
            IN_TRAP     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                REDIRECT_PC <= trap_pc;
                if (exc_any) begin
                    CAUSE <= XLEN'(exc_idx);
                    EPC   <= EXC_PC;
                    TVAL  <= EXC_TVAL;
                end else begin
                    CAUSE <= {1'b1, (XLEN-1)'(irq_idx)};
                    EPC   <= NEXT_PC;
                    TVAL  <= '0;
                end
            end
            if (ret) REDIRECT_PC <= EPC;
            if (state == ENTER && ACK)  IN_TRAP <= 1'b1;
            if (state == RETURN && ACK) IN_TRAP <= 1'b0;
        end
    end

    assign REDIRECT = (state == ENTER) || (state == RETURN);
    assign FLUSH    = ~RST & ACK & REDIRECT;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: directed trap/return sequences,
// redirect contents checked by a monitor on each new redirect.
module tb_trap_controller;

    logic        CLK;
    logic        RST;
    logic [15:0] EXC_VALID;
    logic [63:0] EXC_PC;
    logic [63:0] EXC_TVAL;
    logic [11:0] IRQ_PENDING;
    logic [11:0] IRQ_ENABLE;
    logic        GIE;
    logic [63:0] NEXT_PC;
    logic [63:0] MTVEC;
    logic        MRET;
    logic        ACK;
    logic        REDIRECT;
    logic [63:0] REDIRECT_PC;
    logic [63:0] CAUSE;
    logic [63:0] EPC;
    logic [63:0] TVAL;
    logic        IN_TRAP;
    logic        FLUSH;

    trap_controller dut (
        .CLK(CLK), .RST(RST),
        .EXC_VALID(EXC_VALID), .EXC_PC(EXC_PC), .EXC_TVAL(EXC_TVAL),
        .IRQ_PENDING(IRQ_PENDING), .IRQ_ENABLE(IRQ_ENABLE), .GIE(GIE),
        .NEXT_PC(NEXT_PC), .MTVEC(MTVEC), .MRET(MRET), .ACK(ACK),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .CAUSE(CAUSE),
        .EPC(EPC), .TVAL(TVAL), .IN_TRAP(IN_TRAP), .FLUSH(FLUSH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] cause;
        logic [63:0] epc;
        logic [63:0] tval;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;
    logic prev_redir = 1'b1;

    localparam logic [63:0] IRQ_FLAG = 64'h8000_0000_0000_0000;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_redirect(input logic [63:0] pc, input logic [63:0] cause,
                                   input logic [63:0] epc, input logic [63:0] tval);
        exp_t e;
        e.pc = pc; e.cause = cause; e.epc = epc; e.tval = tval;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_redirect"}, 64'(REDIRECT), 64'd0);
        check({tag, "_redirect_pc"}, REDIRECT_PC, 64'd0);
        check({tag, "_cause"}, CAUSE, 64'd0);
        check({tag, "_epc"}, EPC, 64'd0);
        check({tag, "_tval"}, TVAL, 64'd0);
        check({tag, "_in_trap"}, 64'(IN_TRAP), 64'd0);
        check({tag, "_flush"}, 64'(FLUSH), 64'd0);
    endtask

    // Monitor: every fresh redirect must match the oldest expectation.
    always @(negedge CLK) begin
        if (REDIRECT === 1'b1 && prev_redir === 1'b0) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_redirect", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_redirect_pc", REDIRECT_PC, e.pc);
                check("mon_cause", CAUSE, e.cause);
                check("mon_epc", EPC, e.epc);
                check("mon_tval", TVAL, e.tval);
            end
        end
        prev_redir = REDIRECT;
    end

    initial begin
        RST = 1'b1; EXC_VALID = '0; EXC_PC = '0; EXC_TVAL = '0;
        IRQ_PENDING = '0; IRQ_ENABLE = '0; GIE = 1'b0; NEXT_PC = '0;
        MTVEC = '0; MRET = 1'b0; ACK = 1'b0;
        step(); step();
        check_reset_vals("rst");
        RST = 1'b0;
        step();

        // Exception, lowest index (2) wins over bit 5
        EXC_VALID = 16'h0024; EXC_PC = 64'h1000; EXC_TVAL = 64'hDEAD;
        MTVEC = 64'h8000;
        expect_redirect(64'h8000, 64'd2, 64'h1000, 64'hDEAD);
        step();
        for (int k = 0; k < 5; k++) begin
            check("hold_redirect", 64'(REDIRECT), 64'd1);
            check("hold_cause", CAUSE, 64'd2);
            check("hold_epc", EPC, 64'h1000);
            check("hold_pc", REDIRECT_PC, 64'h8000);
            check("hold_no_flush", 64'(FLUSH), 64'd0);
            EXC_VALID = 16'h0001; EXC_PC = 64'h9999;
            step();
        end
        check("ack_redirect", 64'(REDIRECT), 64'd1);
        ACK = 1'b1;
        #1 check("ack_flush", 64'(FLUSH), 64'd1);
        step();
        ACK = 1'b0; EXC_VALID = '0;
        check("handler_in_trap", 64'(IN_TRAP), 64'd1);
        check("handler_no_redirect", 64'(REDIRECT), 64'd0);
        check("handler_no_flush", 64'(FLUSH), 64'd0);

        // Interrupt while in handler must be masked
        GIE = 1'b1; IRQ_PENDING = 12'h880; IRQ_ENABLE = 12'h880;
        step(); step();
        check("irq_masked_redirect", 64'(REDIRECT), 64'd0);
        check("irq_masked_in_trap", 64'(IN_TRAP), 64'd1);

        // MRET, ACK after two cycles
        MRET = 1'b1;
        expect_redirect(64'h1000, 64'd2, 64'h1000, 64'hDEAD);
        step();
        MRET = 1'b0;
        check("ret_redirect", 64'(REDIRECT), 64'd1);
        check("ret_pc", REDIRECT_PC, 64'h1000);
        step();
        check("ret_wait_no_flush", 64'(FLUSH), 64'd0);
        ACK = 1'b1;
        #1 check("ret_ack_flush", 64'(FLUSH), 64'd1);
        MTVEC = 64'h8001; NEXT_PC = 64'h2000;
        expect_redirect(64'h802C, IRQ_FLAG | 64'd11, 64'h2000, 64'd0);
        step();
        ACK = 1'b0;
        check("ret_in_trap_clr", 64'(IN_TRAP), 64'd0);
        check("ret_idle_redirect", 64'(REDIRECT), 64'd0);

        // Pending interrupt is taken right after returning to idle
        step();
        check("irq_taken", 64'(REDIRECT), 64'd1);
        IRQ_PENDING = '0;
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        check("irq_handler", 64'(IN_TRAP), 64'd1);

        // Nested exception beats MRET in the same cycle
        EXC_VALID = 16'h0020; MRET = 1'b1;
        EXC_PC = 64'h3000; EXC_TVAL = 64'h55;
        expect_redirect(64'h8000, 64'd5, 64'h3000, 64'h55);
        step();
        EXC_VALID = '0; MRET = 1'b0;
        check("nest_cause", CAUSE, 64'd5);
        check("nest_pc", REDIRECT_PC, 64'h8000);
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        check("nest_in_trap", 64'(IN_TRAP), 64'd1);
        check("nest_no_return", 64'(REDIRECT), 64'd0);

        // Reset while a redirect awaits ACK
        EXC_VALID = 16'h0100; EXC_PC = 64'h4000; EXC_TVAL = 64'h77;
        expect_redirect(64'h8000, 64'd8, 64'h4000, 64'h77);
        step();
        EXC_VALID = '0;
        check("pre_rst_redirect", 64'(REDIRECT), 64'd1);
        RST = 1'b1;
        step();
        check_reset_vals("mid_rst");
        RST = 1'b0;
        step();
        check("post_rst_idle", 64'(REDIRECT), 64'd0);

        // Vectored interrupt target wraps modulo 2^64
        MTVEC = 64'hFFFF_FFFF_FFFF_FFFD; NEXT_PC = 64'h5000;
        IRQ_PENDING = 12'h004; IRQ_ENABLE = 12'h004;
        expect_redirect(64'h4, IRQ_FLAG | 64'd2, 64'h5000, 64'd0);
        step();
        IRQ_PENDING = '0;
        check("wrap_redirect", 64'(REDIRECT), 64'd1);
        ACK = 1'b1;
        step();
        ACK = 1'b0; MRET = 1'b1;
        expect_redirect(64'h5000, IRQ_FLAG | 64'd2, 64'h5000, 64'd0);
        step();
        MRET = 1'b0; ACK = 1'b1;
        step();
        ACK = 1'b0;
        check("wrap_back_idle", 64'(IN_TRAP), 64'd0);

        // Exception beats a simultaneous interrupt; MRET in idle ignored
        MTVEC = 64'h8001;
        EXC_VALID = 16'h0008; EXC_PC = 64'h6000; EXC_TVAL = 64'h99;
        IRQ_PENDING = 12'h880; IRQ_ENABLE = 12'h880; MRET = 1'b1;
        expect_redirect(64'h8000, 64'd3, 64'h6000, 64'h99);
        step();
        EXC_VALID = '0; IRQ_PENDING = '0; MRET = 1'b0;
        check("prio_cause", CAUSE, 64'd3);
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        step(); step();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
